qword_to_axis: RTL and testbench

- Per-queue egress stage that drains one 144-bit replay queue FIFO, which is filled by the SRAM reader with {mem_qrh, mem_qrl} words.
- Splits each word into two 72-bit half-words, decodes their control bits and emits a 64-bit AXI4-Stream packet stream toward the output port arbiter.
- One instance per queue.
- Gates packet starts on an enable and keeps replay statistics.

---
 rtl/qword_to_axis.sv | 175 +++++++++++++++++
 tb/tb_qword_to_axis.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qword_to_axis.sv
// Per-queue egress stage: drains {high,low} 72-bit half-word pairs from a FWFT
// replay FIFO and emits them as a 64-bit AXI4-Stream with per-queue statistics.
module qword_to_axis #(
    parameter int FIFO_DATA_WIDTH = 144,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [7:0]                 m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    input  logic                       q_enable,
    input  logic                       clear_stats,
    output logic [CNT_WIDTH-1:0]       pkt_count,
    output logic [CNT_WIDTH-1:0]       byte_count,
    output logic [CNT_WIDTH-1:0]       err_count,
    output logic                       in_packet
);

    localparam int HALF_W = FIFO_DATA_WIDTH / 2;
    localparam int NB_LSB = AXIS_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t state, state_next;

    // pkt_open tracks packet framing on the load side, so gating decisions are
    // not delayed by a stalled tlast beat sitting in the output register.
    logic                       pkt_open, pkt_open_next;
    logic                       low_fill_mid;
    logic                       sel_high;
    logic                       h_valid, h_last;
    logic [2:0]                 h_nm1;
    logic [AXIS_DATA_WIDTH-1:0] h_data;
    logic [7:0]                 h_keep;
    logic                       bad_len, fill_err;
    logic                       active, can_load, consume, load, accepted;
    logic [1:0]                 err_inc;
    logic                       reserved_unused;

    assign reserved_unused = ^{fifo_dout[FIFO_DATA_WIDTH-3:HALF_W+NB_LSB+3],
                               fifo_dout[HALF_W-3:NB_LSB+3]};

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    always_comb begin
        sel_high = (state == HIGH);
        h_valid  = sel_high ? fifo_dout[FIFO_DATA_WIDTH-1] : fifo_dout[HALF_W-1];
        h_last   = sel_high ? fifo_dout[FIFO_DATA_WIDTH-2] : fifo_dout[HALF_W-2];
        h_nm1    = sel_high ? fifo_dout[HALF_W+NB_LSB+2:HALF_W+NB_LSB]
                            : fifo_dout[NB_LSB+2:NB_LSB];
        h_data   = sel_high ? fifo_dout[HALF_W+AXIS_DATA_WIDTH-1:HALF_W]
                            : fifo_dout[AXIS_DATA_WIDTH-1:0];
        bad_len  = h_valid && !h_last && (h_nm1 != 3'd7);
        case (h_nm1)
            3'd0:    h_keep = 8'h01;
            3'd1:    h_keep = 8'h03;
            3'd2:    h_keep = 8'h07;
            3'd3:    h_keep = 8'h0F;
            3'd4:    h_keep = 8'h1F;
            3'd5:    h_keep = 8'h3F;
            3'd6:    h_keep = 8'h7F;
            default: h_keep = 8'hFF;
        endcase
        if (bad_len) begin
            h_keep = 8'hFF;
        end
    end

    // A filler half is consumed immediately; a real half only when the output
    // register can take it.
    always_comb begin
        can_load      = !m_axis_tvalid || m_axis_tready;
        accepted      = m_axis_tvalid && m_axis_tready;
        active        = (state != IDLE) && !fifo_empty;
        consume       = active && (!h_valid || can_load);
        load          = active && h_valid && can_load;
        pkt_open_next = load ? !h_last : pkt_open;
        fill_err      = sel_high && h_valid && low_fill_mid;
        err_inc       = {1'b0, load && bad_len} + {1'b0, load && fill_err};
        fifo_rd_en    = sel_high && consume;
        state_next    = state;
        case (state)
            IDLE: begin
                if (!fifo_empty && (pkt_open || q_enable)) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (consume) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (consume) begin
                    state_next = (pkt_open_next || q_enable) ? LOW : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pkt_open     <= 1'b0;
            low_fill_mid <= 1'b0;
            in_packet    <= 1'b0;
        end else begin
            state    <= state_next;
            pkt_open <= pkt_open_next;
            if (state == LOW && consume) begin
                low_fill_mid <= !h_valid && pkt_open;
            end
            if (accepted) begin
                in_packet <= !m_axis_tlast;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= h_data;
            m_axis_tkeep  <= h_keep;
            m_axis_tlast  <= h_last;
        end else if (accepted) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Clear beats any increment landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count  <= '0;
            byte_count <= '0;
            err_count  <= '0;
        end else if (clear_stats) begin
            pkt_count  <= '0;
            byte_count <= '0;
            err_count  <= '0;
        end else begin
            if (accepted && m_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (accepted) begin
                byte_count <= byte_count + CNT_WIDTH'(popcount8(m_axis_tkeep));
            end
            err_count <= err_count + CNT_WIDTH'(err_inc);
        end
    end

endmodule

// File: tb/tb_qword_to_axis.sv
// Directed bench for qword_to_axis: a queue-backed FWFT FIFO feeds the DUT and
// accepted beats are collected and compared against hand-written expectations.
module tb_qword_to_axis;

    logic         clk = 1'b0;
    logic         rst;
    logic [143:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         q_enable;
    logic         clear_stats;
    logic [31:0]  pkt_count;
    logic [31:0]  byte_count;
    logic [31:0]  err_count;
    logic         in_packet;

    logic [143:0] fq[$];
    logic [72:0]  got[$];
    logic [72:0]  exp[$];
    int           total = 0;
    int           bad = 0;
    int           rd_pulses = 0;
    logic         toggle_ready = 1'b0;
    logic         chk_stall = 1'b0;

    always #5 clk = ~clk;

    qword_to_axis dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .q_enable     (q_enable),
        .clear_stats  (clear_stats),
        .pkt_count    (pkt_count),
        .byte_count   (byte_count),
        .err_count    (err_count),
        .in_packet    (in_packet)
    );

    function automatic logic [71:0] hw(input logic v, input logic l,
                                       input logic [2:0] nm1, input logic [63:0] d);
        return {v, l, 3'b000, nm1, d};
    endfunction

    function automatic logic [72:0] bt(input logic last, input logic [7:0] keep,
                                       input logic [63:0] d);
        return {last, keep, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [72:0] observed,
                               input logic [72:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic refreshFifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fq[0];
    endtask

    task automatic applyStimulus(input logic [143:0] word);
        fq.push_back(word);
        refreshFifo();
    endtask

    // One clock: sample just after the falling edge, apply the effects of the
    // rising edge (pop, beat capture, ready toggle) just after it.
    task automatic step();
        logic        pre_rd;
        logic        pre_acc;
        logic [72:0] beat;
        #1;
        pre_rd  = fifo_rd_en;
        pre_acc = m_axis_tvalid && m_axis_tready;
        beat    = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        checkOutput("rd_while_empty", 73'(fifo_rd_en & fifo_empty), 73'd0);
        if (chk_stall && m_axis_tvalid && !m_axis_tready && got.size() < exp.size())
            checkOutput("stall_hold", beat, exp[got.size()]);
        @(posedge clk);
        #1;
        if (pre_rd) begin
            rd_pulses++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        if (pre_acc) got.push_back(beat);
        if (toggle_ready) m_axis_tready = ~m_axis_tready;
        refreshFifo();
        @(negedge clk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic checkBeats(input string tag);
        checkOutput($sformatf("%s_count", tag), 73'(got.size()), 73'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size())
                checkOutput($sformatf("%s_beat%0d", tag, i), got[i], exp[i]);
        end
        got.delete();
        exp.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m_axis_tready = 1'b1;
        q_enable = 1'b0;
        clear_stats = 1'b0;
        refreshFifo();
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_tvalid", 73'(m_axis_tvalid), 73'd0);
        checkOutput("rst_tdata", 73'(m_axis_tdata), 73'd0);
        checkOutput("rst_tkeep", 73'(m_axis_tkeep), 73'd0);
        checkOutput("rst_tlast", 73'(m_axis_tlast), 73'd0);
        checkOutput("rst_rd_en", 73'(fifo_rd_en), 73'd0);
        checkOutput("rst_counts", 73'({pkt_count, byte_count, err_count}), 73'd0);
        checkOutput("rst_in_packet", 73'(in_packet), 73'd0);
        rst = 1'b0;
        q_enable = 1'b1;
        @(negedge clk);
        runCycles(2);

        // single-word packet and start latency
        applyStimulus({hw(1'b1, 1'b1, 3'd3, 64'hDEADBEEF_CAFEF00D),
                       hw(1'b1, 1'b0, 3'd7, 64'h07060504_03020100)});
        exp.push_back(bt(1'b0, 8'hFF, 64'h07060504_03020100));
        exp.push_back(bt(1'b1, 8'h0F, 64'hDEADBEEF_CAFEF00D));
        step();
        checkOutput("t1_lat_c1", 73'(m_axis_tvalid), 73'd0);
        step();
        checkOutput("t1_lat_c2", 73'(m_axis_tvalid), 73'd1);
        checkOutput("t1_in_pkt_pre", 73'(in_packet), 73'd0);
        step();
        checkOutput("t1_in_pkt_mid", 73'(in_packet), 73'd1);
        runCycles(5);
        checkBeats("t1");
        checkOutput("t1_pkt", 73'(pkt_count), 73'd1);
        checkOutput("t1_bytes", 73'(byte_count), 73'd12);
        checkOutput("t1_err", 73'(err_count), 73'd0);
        checkOutput("t1_rd_pulses", 73'(rd_pulses), 73'd1);
        checkOutput("t1_in_pkt_end", 73'(in_packet), 73'd0);

        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        checkOutput("clr_counts", 73'({pkt_count, byte_count, err_count}), 73'd0);
        rd_pulses = 0;

        // 3-word packet under tready toggling
        toggle_ready = 1'b1;
        chk_stall = 1'b1;
        applyStimulus({hw(1'b1, 1'b0, 3'd7, 64'h1111), hw(1'b1, 1'b0, 3'd7, 64'h1000)});
        applyStimulus({hw(1'b1, 1'b0, 3'd7, 64'h3333), hw(1'b1, 1'b0, 3'd7, 64'h2222)});
        applyStimulus({hw(1'b1, 1'b1, 3'd7, 64'h5555), hw(1'b1, 1'b0, 3'd7, 64'h4444)});
        exp.push_back(bt(1'b0, 8'hFF, 64'h1000));
        exp.push_back(bt(1'b0, 8'hFF, 64'h1111));
        exp.push_back(bt(1'b0, 8'hFF, 64'h2222));
        exp.push_back(bt(1'b0, 8'hFF, 64'h3333));
        exp.push_back(bt(1'b0, 8'hFF, 64'h4444));
        exp.push_back(bt(1'b1, 8'hFF, 64'h5555));
        runCycles(24);
        toggle_ready = 1'b0;
        chk_stall = 1'b0;
        m_axis_tready = 1'b1;
        checkBeats("t2");
        checkOutput("t2_bytes", 73'(byte_count), 73'd48);
        checkOutput("t2_pkt", 73'(pkt_count), 73'd1);
        checkOutput("t2_rd_pulses", 73'(rd_pulses), 73'd3);

        // low filler, high single-byte packet
        applyStimulus({hw(1'b1, 1'b1, 3'd0, 64'hEE), hw(1'b0, 1'b0, 3'd0, 64'h0)});
        exp.push_back(bt(1'b1, 8'h01, 64'hEE));
        runCycles(6);
        checkBeats("t3");
        checkOutput("t3_err", 73'(err_count), 73'd0);
        checkOutput("t3_bytes", 73'(byte_count), 73'd49);

        // q_enable dropped mid-packet: packet completes, next one held back
        applyStimulus({hw(1'b1, 1'b0, 3'd7, 64'hC1), hw(1'b1, 1'b0, 3'd7, 64'hC0)});
        applyStimulus({hw(1'b1, 1'b0, 3'd7, 64'hC3), hw(1'b1, 1'b0, 3'd7, 64'hC2)});
        applyStimulus({hw(1'b1, 1'b0, 3'd7, 64'hC5), hw(1'b1, 1'b0, 3'd7, 64'hC4)});
        applyStimulus({hw(1'b1, 1'b1, 3'd7, 64'hC7), hw(1'b1, 1'b0, 3'd7, 64'hC6)});
        applyStimulus({hw(1'b1, 1'b1, 3'd3, 64'hE1), hw(1'b1, 1'b0, 3'd7, 64'hE0)});
        for (int i = 0; i < 20 && got.size() < 1; i++) step();
        checkOutput("t4_first_wait", 73'(got.size() >= 1), 73'd1);
        q_enable = 1'b0;
        runCycles(30);
        for (int i = 0; i < 7; i++) exp.push_back(bt(1'b0, 8'hFF, 64'hC0 + 64'(i)));
        exp.push_back(bt(1'b1, 8'hFF, 64'hC7));
        checkBeats("t4");
        checkOutput("t4_held_queued", 73'(fifo_empty), 73'd0);
        checkOutput("t4_held_tvalid", 73'(m_axis_tvalid), 73'd0);
        checkOutput("t4_held_in_pkt", 73'(in_packet), 73'd0);
        q_enable = 1'b1;
        runCycles(8);
        exp.push_back(bt(1'b0, 8'hFF, 64'hE0));
        exp.push_back(bt(1'b1, 8'h0F, 64'hE1));
        checkBeats("t4b");
        checkOutput("t4_pkt", 73'(pkt_count), 73'd4);
        checkOutput("t4_bytes", 73'(byte_count), 73'd125);

        // short non-last half is widened and counted
        applyStimulus({hw(1'b1, 1'b1, 3'd7, 64'hAB1), hw(1'b1, 1'b0, 3'd2, 64'hAB0)});
        exp.push_back(bt(1'b0, 8'hFF, 64'hAB0));
        exp.push_back(bt(1'b1, 8'hFF, 64'hAB1));
        runCycles(6);
        checkBeats("t5");
        checkOutput("t5_err", 73'(err_count), 73'd1);

        // filler low half mid-packet followed by a valid high half
        applyStimulus({hw(1'b1, 1'b0, 3'd7, 64'hF1), hw(1'b1, 1'b0, 3'd7, 64'hF0)});
        applyStimulus({hw(1'b1, 1'b1, 3'd7, 64'hF3), hw(1'b0, 1'b0, 3'd0, 64'h0)});
        exp.push_back(bt(1'b0, 8'hFF, 64'hF0));
        exp.push_back(bt(1'b0, 8'hFF, 64'hF1));
        exp.push_back(bt(1'b1, 8'hFF, 64'hF3));
        runCycles(10);
        checkBeats("t5b");
        checkOutput("t5b_err", 73'(err_count), 73'd2);
        checkOutput("t5b_pkt", 73'(pkt_count), 73'd6);
        checkOutput("t5b_bytes", 73'(byte_count), 73'd165);

        // reset while a beat is held on the output
        m_axis_tready = 1'b0;
        applyStimulus({hw(1'b1, 1'b0, 3'd7, 64'hD1), hw(1'b1, 1'b0, 3'd7, 64'hD0)});
        applyStimulus({hw(1'b1, 1'b1, 3'd7, 64'hD3), hw(1'b1, 1'b0, 3'd7, 64'hD2)});
        for (int i = 0; i < 10 && !m_axis_tvalid; i++) step();
        checkOutput("t6_tvalid_seen", 73'(m_axis_tvalid), 73'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_tvalid", 73'(m_axis_tvalid), 73'd0);
        checkOutput("t6_rst_counts", 73'({pkt_count, byte_count, err_count}), 73'd0);
        checkOutput("t6_rst_in_pkt", 73'(in_packet), 73'd0);
        fq.delete();
        refreshFifo();
        step();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        runCycles(5);
        checkOutput("t6_idle_tvalid", 73'(m_axis_tvalid), 73'd0);
        checkOutput("t6_idle_beats", 73'(got.size()), 73'd0);
        checkOutput("t6_idle_pkt", 73'(pkt_count), 73'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
